// File: rtl/spaceship_laser.sv
// rtl/spaceship_laser.sv - player laser: launch on fire, fly up per frame, saucer hit test, cooldown
// Optional feature macro: LASER_AUTOFIRE_EN (fire is level-sensitive while IDLE).
module spaceship_laser #(
  parameter logic [10:0] LASER_START_Y   = 11'd440,
  parameter logic [10:0] LASER_SPEED     = 11'd4,
  parameter logic [10:0] LASER_HEIGHT    = 11'd10,
  parameter logic [10:0] LASER_HALF_W    = 11'd1,
  parameter logic [7:0]  COOLDOWN_FRAMES = 8'd8,
  parameter logic [10:0] SAUCER_HALF_LEN = 11'd20,
  parameter logic [10:0] SAUCER_HALF_H   = 11'd8,
  parameter logic [10:0] SAUCER_MAX_X    = 11'd660,
  parameter logic [10:0] PARK_X          = 11'd0,
  parameter logic [10:0] PARK_Y          = 11'd480,
  parameter logic [7:0]  COLOR_LASER     = 8'b11111111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  input  logic [1:0]  mode,
  input  logic [10:0] xCoord,
  input  logic [10:0] yCoord,
  input  logic        fire,
  input  logic [10:0] ship_xCoord,
  input  logic [10:0] saucer_xCoord,
  input  logic [10:0] saucer_yCoord,
  output logic [10:0] laser_xCoord,
  output logic [10:0] laser_yCoord,
  output logic        saucer_hit,
  output logic        is_laser,
  output logic [7:0]  rgb
);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic        fire_q;
  logic        fire_pending_q, fire_pending_d;
  logic        hit_q, hit_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        frame_tick, clear, fire_req, hit_now;
  logic [10:0] next_y;
  logic [7:0]  cnt_next;

  assign frame_tick = (xCoord == 11'd0) && (yCoord == 11'd0);
  assign clear      = restart || (mode != 2'd2);
  assign cnt_next   = cnt_q + 8'd1;
  assign next_y     = (y_q > LASER_SPEED) ? (y_q - LASER_SPEED) : 11'd0;

`ifdef LASER_AUTOFIRE_EN
  assign fire_req = fire;
`else
  assign fire_req = fire & ~fire_q;
`endif

  // Window bounds are rearranged as additions on 12 bits so a saucer near the origin cannot wrap.
  assign hit_now = (saucer_xCoord <= SAUCER_MAX_X)
                && ({1'b0, x_q} + {1'b0, SAUCER_HALF_LEN} >= {1'b0, saucer_xCoord})
                && ({1'b0, x_q} <= {1'b0, saucer_xCoord} + {1'b0, SAUCER_HALF_LEN})
                && ({1'b0, next_y} <= {1'b0, saucer_yCoord} + {1'b0, SAUCER_HALF_H})
                && ({1'b0, next_y} + {1'b0, LASER_HEIGHT} + {1'b0, SAUCER_HALF_H}
                    >= {1'b0, saucer_yCoord});

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    fire_pending_d = fire_pending_q;
    hit_d          = 1'b0;
    cnt_d          = cnt_q;
    if (clear) begin
      state_d        = IDLE;
      x_d            = PARK_X;
      y_d            = PARK_Y;
      fire_pending_d = 1'b0;
      cnt_d          = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire_req) fire_pending_d = 1'b1;
          if (frame_tick && fire_pending_q) begin
            state_d        = FLYING;
            x_d            = ship_xCoord;
            y_d            = LASER_START_Y;
            fire_pending_d = 1'b0;
          end
        end
        FLYING: begin
          if (frame_tick) begin
            if (hit_now || (y_q <= LASER_SPEED)) begin
              hit_d   = hit_now;
              state_d = COOLDOWN;
              x_d     = PARK_X;
              y_d     = PARK_Y;
              cnt_d   = 8'd0;
            end else begin
              y_d = next_y;
            end
          end
        end
        COOLDOWN: begin
          if (frame_tick) begin
            if (cnt_next >= COOLDOWN_FRAMES) begin
              state_d = IDLE;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_next;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    fire_q <= fire;
    if (rst) begin
      state_q        <= IDLE;
      x_q            <= PARK_X;
      y_q            <= PARK_Y;
      fire_pending_q <= 1'b0;
      hit_q          <= 1'b0;
      cnt_q          <= 8'd0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      fire_pending_q <= fire_pending_d;
      hit_q          <= hit_d;
      cnt_q          <= cnt_d;
    end
  end

  assign laser_xCoord = x_q;
  assign laser_yCoord = y_q;
  assign saucer_hit   = hit_q;

  assign is_laser = (state_q == FLYING)
                 && ({1'b0, xCoord} + {1'b0, LASER_HALF_W} >= {1'b0, x_q})
                 && ({1'b0, xCoord} <= {1'b0, x_q} + {1'b0, LASER_HALF_W})
                 && (yCoord >= y_q)
                 && ({1'b0, yCoord} < {1'b0, y_q} + {1'b0, LASER_HEIGHT});
  assign rgb = is_laser ? COLOR_LASER : 8'h00;

endmodule

// File: tb/tb_spaceship_laser.sv
// tb/tb_spaceship_laser.sv - directed self-checking bench for spaceship_laser
module tb_spaceship_laser;
  logic        clk = 1'b0;
  logic        rst, restart, fire;
  logic [1:0]  mode;
  logic [10:0] xCoord, yCoord, ship_xCoord, saucer_xCoord, saucer_yCoord;
  logic [10:0] laser_xCoord, laser_yCoord;
  logic        saucer_hit, is_laser;
  logic [7:0]  rgb;

  int checks = 0;
  int errors = 0;
  logic hit_seen = 1'b0;

  spaceship_laser dut (
    .clk(clk), .rst(rst), .restart(restart), .mode(mode),
    .xCoord(xCoord), .yCoord(yCoord), .fire(fire),
    .ship_xCoord(ship_xCoord), .saucer_xCoord(saucer_xCoord), .saucer_yCoord(saucer_yCoord),
    .laser_xCoord(laser_xCoord), .laser_yCoord(laser_yCoord),
    .saucer_hit(saucer_hit), .is_laser(is_laser), .rgb(rgb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk); xCoord = 11'd0; yCoord = 11'd0;
    @(negedge clk); xCoord = 11'd700; yCoord = 11'd600;
    hit_seen = saucer_hit;
  endtask

  task automatic press_fire();
    @(negedge clk); fire = 1'b1;
    @(negedge clk); fire = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); xCoord = 11'd0; yCoord = 11'd480; #1;
    checks++;
    if (laser_xCoord !== 11'd0 || laser_yCoord !== 11'd480 || is_laser !== 1'b0 ||
        saucer_hit !== 1'b0 || rgb !== 8'h00) begin
      errors++;
      $display("FAIL reset: x=%0d y=%0d is_laser=%b hit=%b rgb=%h, want 0 480 0 0 00",
               laser_xCoord, laser_yCoord, is_laser, saucer_hit, rgb);
    end
    rst = 1'b0; xCoord = 11'd700; yCoord = 11'd600;
  endtask

  task automatic test_launch();
    logic any_hit;
    do_reset();
    saucer_xCoord = 11'd1998; saucer_yCoord = 11'd100; ship_xCoord = 11'd320;
    press_fire();
    tick();
    checks++;
    if (laser_xCoord !== 11'd320 || laser_yCoord !== 11'd440) begin
      errors++;
      $display("FAIL launch: got (%0d,%0d), want (320,440)", laser_xCoord, laser_yCoord);
    end
    any_hit = hit_seen;
    for (int i = 0; i < 10; i++) begin
      tick();
      any_hit = any_hit | hit_seen;
    end
    checks++;
    if (laser_xCoord !== 11'd320 || laser_yCoord !== 11'd400 || any_hit !== 1'b0) begin
      errors++;
      $display("FAIL flight10: got (%0d,%0d) hit=%b, want (320,400) hit=0",
               laser_xCoord, laser_yCoord, any_hit);
    end
    @(negedge clk); xCoord = 11'd319; yCoord = 11'd409; #1;
    checks++;
    if (is_laser !== 1'b1 || rgb !== 8'hFF) begin
      errors++;
      $display("FAIL pixel_in: is_laser=%b rgb=%h, want 1 ff", is_laser, rgb);
    end
    xCoord = 11'd322; #1;
    checks++;
    if (is_laser !== 1'b0 || rgb !== 8'h00) begin
      errors++;
      $display("FAIL pixel_right: is_laser=%b rgb=%h, want 0 00", is_laser, rgb);
    end
    xCoord = 11'd321; yCoord = 11'd410; #1;
    checks++;
    if (is_laser !== 1'b0) begin
      errors++;
      $display("FAIL pixel_below: is_laser=%b, want 0", is_laser);
    end
    yCoord = 11'd399; #1;
    checks++;
    if (is_laser !== 1'b0) begin
      errors++;
      $display("FAIL pixel_above: is_laser=%b, want 0", is_laser);
    end
    xCoord = 11'd700; yCoord = 11'd600;
    ship_xCoord = 11'd100;
    tick();
    checks++;
    if (laser_xCoord !== 11'd320 || laser_yCoord !== 11'd396) begin
      errors++;
      $display("FAIL x_hold: got (%0d,%0d), want (320,396)", laser_xCoord, laser_yCoord);
    end
    ship_xCoord = 11'd320;
  endtask

  task automatic test_top_exit_cooldown();
    do_reset();
    saucer_xCoord = 11'd1998; saucer_yCoord = 11'd100;
    press_fire();
    tick();
    for (int i = 0; i < 109; i++) tick();
    checks++;
    if (laser_xCoord !== 11'd320 || laser_yCoord !== 11'd4) begin
      errors++;
      $display("FAIL near_top: got (%0d,%0d), want (320,4)", laser_xCoord, laser_yCoord);
    end
    tick();
    checks++;
    if (laser_xCoord !== 11'd0 || laser_yCoord !== 11'd480 || hit_seen !== 1'b0) begin
      errors++;
      $display("FAIL top_park: got (%0d,%0d) hit=%b, want (0,480) hit=0",
               laser_xCoord, laser_yCoord, hit_seen);
    end
    for (int i = 0; i < 8; i++) begin
      press_fire();
      tick();
      checks++;
      if (laser_yCoord !== 11'd480) begin
        errors++;
        $display("FAIL cooldown_drop%0d: y=%0d, want 480", i, laser_yCoord);
      end
    end
    press_fire();
    tick();
    checks++;
    if (laser_xCoord !== 11'd320 || laser_yCoord !== 11'd440) begin
      errors++;
      $display("FAIL after_cooldown: got (%0d,%0d), want (320,440)", laser_xCoord, laser_yCoord);
    end
  endtask

  task automatic test_hit();
    int n;
    logic [10:0] prev_y;
    logic saw64;
    do_reset();
    saucer_xCoord = 11'd330; saucer_yCoord = 11'd58;
    press_fire();
    tick();
    n = 0; prev_y = laser_yCoord; saw64 = 1'b0; hit_seen = 1'b0;
    while (!hit_seen && n < 120) begin
      prev_y = laser_yCoord;
      tick();
      n++;
      if (laser_yCoord == 11'd64) saw64 = 1'b1;
    end
    checks++;
    if (hit_seen !== 1'b1 || n != 94 || prev_y !== 11'd68) begin
      errors++;
      $display("FAIL hit_tick: hit=%b ticks=%0d prev_y=%0d, want 1 94 68", hit_seen, n, prev_y);
    end
    checks++;
    if (laser_xCoord !== 11'd0 || laser_yCoord !== 11'd480 || saw64 !== 1'b0) begin
      errors++;
      $display("FAIL hit_park: got (%0d,%0d) saw64=%b, want (0,480) 0",
               laser_xCoord, laser_yCoord, saw64);
    end
    @(negedge clk);
    checks++;
    if (saucer_hit !== 1'b0) begin
      errors++;
      $display("FAIL hit_pulse: saucer_hit=%b one cycle later, want 0", saucer_hit);
    end
  endtask

  task automatic test_restart();
    do_reset();
    saucer_xCoord = 11'd1998; saucer_yCoord = 11'd100;
    press_fire();
    tick();
    for (int i = 0; i < 35; i++) tick();
    checks++;
    if (laser_yCoord !== 11'd300) begin
      errors++;
      $display("FAIL pre_restart: y=%0d, want 300", laser_yCoord);
    end
    @(negedge clk); restart = 1'b1; xCoord = 11'd320; yCoord = 11'd305;
    @(negedge clk); #1;
    checks++;
    if (laser_xCoord !== 11'd0 || laser_yCoord !== 11'd480 || is_laser !== 1'b0) begin
      errors++;
      $display("FAIL restart: got (%0d,%0d) is_laser=%b, want (0,480) 0",
               laser_xCoord, laser_yCoord, is_laser);
    end
    restart = 1'b0; xCoord = 11'd700; yCoord = 11'd600;
    press_fire();
    tick();
    checks++;
    if (laser_yCoord !== 11'd440) begin
      errors++;
      $display("FAIL restart_idle: y=%0d, want 440", laser_yCoord);
    end
    tick();
    @(negedge clk); mode = 2'd1;
    @(negedge clk);
    checks++;
    if (laser_xCoord !== 11'd0 || laser_yCoord !== 11'd480) begin
      errors++;
      $display("FAIL mode_off: got (%0d,%0d), want (0,480)", laser_xCoord, laser_yCoord);
    end
    mode = 2'd2;
    press_fire();
    @(negedge clk); restart = 1'b1;
    @(negedge clk); restart = 1'b0;
    tick();
    checks++;
    if (laser_yCoord !== 11'd480) begin
      errors++;
      $display("FAIL pending_lost: y=%0d, want 480", laser_yCoord);
    end
  endtask

  task automatic test_fire_held();
    int n;
    do_reset();
    saucer_xCoord = 11'd330; saucer_yCoord = 11'd400;
    @(negedge clk); fire = 1'b1;
    tick();
    n = 0; hit_seen = 1'b0;
    while (!hit_seen && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (hit_seen !== 1'b1 || n != 8 || laser_yCoord !== 11'd480) begin
      errors++;
      $display("FAIL held_hit: hit=%b ticks=%0d y=%0d, want 1 8 480", hit_seen, n, laser_yCoord);
    end
    for (int i = 0; i < 8; i++) tick();
    tick();
    checks++;
`ifdef LASER_AUTOFIRE_EN
    if (laser_xCoord !== 11'd320 || laser_yCoord !== 11'd440) begin
      errors++;
      $display("FAIL held_relaunch: got (%0d,%0d), want (320,440)", laser_xCoord, laser_yCoord);
    end
`else
    if (laser_xCoord !== 11'd0 || laser_yCoord !== 11'd480) begin
      errors++;
      $display("FAIL held_no_relaunch: got (%0d,%0d), want (0,480)", laser_xCoord, laser_yCoord);
    end
`endif
    fire = 1'b0;
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; mode = 2'd2; fire = 1'b0;
    xCoord = 11'd700; yCoord = 11'd600; ship_xCoord = 11'd320;
    saucer_xCoord = 11'd1998; saucer_yCoord = 11'd100;
    test_reset();
    test_launch();
    test_top_exit_cooldown();
    test_hit();
    test_restart();
    test_fire_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
